// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - power-on / clock-enable / soft reset sequencer with soft-reboot support
module reset_seq_ctrl #(
    parameter int P_RST_CYCLES    = 16,
    parameter int CLK_ENB_DLY     = 8,
    parameter int S_RST_DLY       = 8,
    parameter int SOFT_RST_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       e_reset_n,
    input  logic       soft_reboot_req,
    input  logic       cpu_rst_rel,
    output logic       p_reset_n,
    output logic       clk_enb,
    output logic       s_reset_n,
    output logic       cpu_reset_n,
    output logic [2:0] seq_state,
    output logic [7:0] reboot_cnt
);

    typedef enum logic [2:0] {
        P_RST        = 3'd0,
        CLK_WAIT     = 3'd1,
        S_WAIT       = 3'd2,
        RUN          = 3'd3,
        SOFT_RST     = 3'd4,
        SOFT_CLK_OFF = 3'd5
    } state_t;

    // Counter reload values: a state lasting N cycles starts at N-1 and exits on zero.
    localparam logic [CNT_W-1:0] LD_P    = CNT_W'(P_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CLK  = CNT_W'(CLK_ENB_DLY - 1);
    localparam logic [CNT_W-1:0] LD_S    = CNT_W'(S_RST_DLY - 1);
    localparam logic [CNT_W-1:0] LD_SOFT = CNT_W'(SOFT_RST_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_s1;
    logic             req_s2;
    logic             cnt_zero;

    assign cnt_zero  = (cnt == '0);
    assign seq_state = state;

    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
        end else begin
            req_s1 <= soft_reboot_req;
            req_s2 <= req_s1;
        end
    end

    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            state       <= P_RST;
            cnt         <= LD_P;
            p_reset_n   <= 1'b0;
            clk_enb     <= 1'b0;
            s_reset_n   <= 1'b0;
            cpu_reset_n <= 1'b0;
            reboot_cnt  <= 8'd0;
        end else begin
            cnt         <= cnt - 1'b1;
            cpu_reset_n <= 1'b0;
            case (state)
                P_RST: begin
                    if (cnt_zero) begin
                        state     <= CLK_WAIT;
                        cnt       <= LD_CLK;
                        p_reset_n <= 1'b1;
                    end
                end
                CLK_WAIT: begin
                    if (cnt_zero) begin
                        state   <= S_WAIT;
                        cnt     <= LD_S;
                        clk_enb <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_zero) begin
                        state     <= RUN;
                        s_reset_n <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt;
                    if (req_s2) begin
                        state     <= SOFT_RST;
                        cnt       <= LD_SOFT;
                        s_reset_n <= 1'b0;
                        if (reboot_cnt != 8'hff) begin
                            reboot_cnt <= reboot_cnt + 8'd1;
                        end
                    end else begin
                        cpu_reset_n <= cpu_rst_rel;
                    end
                end
                // Clock stays on here so the requester's sticky bit can be cleared.
                SOFT_RST: begin
                    if (cnt_zero) begin
                        state   <= SOFT_CLK_OFF;
                        cnt     <= LD_CLK;
                        clk_enb <= 1'b0;
                    end
                end
                SOFT_CLK_OFF: begin
                    if (cnt_zero) begin
                        state   <= S_WAIT;
                        cnt     <= LD_S;
                        clk_enb <= 1'b1;
                    end
                end
                default: begin
                    state     <= P_RST;
                    cnt       <= LD_P;
                    p_reset_n <= 1'b0;
                    clk_enb   <= 1'b0;
                    s_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - directed table-driven bench for reset_seq_ctrl
module tb_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       e_reset_n;
    logic       soft_reboot_req;
    logic       cpu_rst_rel;
    logic       p_reset_n, clk_enb, s_reset_n, cpu_reset_n;
    logic [2:0] seq_state;
    logic [7:0] reboot_cnt;
    logic       p2, c2, s2, cpu2;
    logic [2:0] st2;
    logic [7:0] rc2;

    always #5 clk = ~clk;

    reset_seq_ctrl dut (
        .clk(clk), .e_reset_n(e_reset_n), .soft_reboot_req(soft_reboot_req),
        .cpu_rst_rel(cpu_rst_rel), .p_reset_n(p_reset_n), .clk_enb(clk_enb),
        .s_reset_n(s_reset_n), .cpu_reset_n(cpu_reset_n), .seq_state(seq_state),
        .reboot_cnt(reboot_cnt)
    );

    reset_seq_ctrl #(.P_RST_CYCLES(1), .CLK_ENB_DLY(1), .S_RST_DLY(1)) dut_min (
        .clk(clk), .e_reset_n(e_reset_n), .soft_reboot_req(soft_reboot_req),
        .cpu_rst_rel(cpu_rst_rel), .p_reset_n(p2), .clk_enb(c2),
        .s_reset_n(s2), .cpu_reset_n(cpu2), .seq_state(st2),
        .reboot_cnt(rc2)
    );

    typedef struct {
        int         cyc;
        logic [2:0] pcs;
        logic       cpu;
        logic [2:0] st;
        logic       chk2;
        logic [2:0] pcs2;
    } vec_t;

    vec_t por_q[$];
    vec_t soft_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int sel, input bit mon_p, input string tag);
        int   e;
        int   n;
        vec_t v;
        e = 0;
        n = (sel == 0) ? por_q.size() : soft_q.size();
        for (int i = 0; i < n; i++) begin
            v = (sel == 0) ? por_q[i] : soft_q[i];
            while (e < v.cyc) begin
                step();
                e++;
                if (mon_p) chk({tag, " p_reset_n held"}, {31'd0, p_reset_n}, 32'd1);
            end
            chk($sformatf("%s@%0d pcs", tag, v.cyc), {29'd0, p_reset_n, clk_enb, s_reset_n}, {29'd0, v.pcs});
            chk($sformatf("%s@%0d cpu", tag, v.cyc), {31'd0, cpu_reset_n}, {31'd0, v.cpu});
            chk($sformatf("%s@%0d state", tag, v.cyc), {29'd0, seq_state}, {29'd0, v.st});
            if (v.chk2)
                chk($sformatf("%s@%0d min pcs", tag, v.cyc), {29'd0, p2, c2, s2}, {29'd0, v.pcs2});
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " outs"}, {28'd0, p_reset_n, clk_enb, s_reset_n, cpu_reset_n}, 32'd0);
        chk({tag, " state"}, {29'd0, seq_state}, 32'd0);
        chk({tag, " reboot_cnt"}, {24'd0, reboot_cnt}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int trans, run_len, max_run, waited, stable, trans_sat;
        bit done;

        // Edges counted from the first clk edge after e_reset_n release.
        por_q.push_back('{1,  3'b000, 1'b0, 3'd0, 1'b1, 3'b100});
        por_q.push_back('{2,  3'b000, 1'b0, 3'd0, 1'b1, 3'b110});
        por_q.push_back('{3,  3'b000, 1'b0, 3'd0, 1'b1, 3'b111});
        por_q.push_back('{15, 3'b000, 1'b0, 3'd0, 1'b0, 3'b000});
        por_q.push_back('{16, 3'b100, 1'b0, 3'd1, 1'b0, 3'b000});
        por_q.push_back('{23, 3'b100, 1'b0, 3'd1, 1'b0, 3'b000});
        por_q.push_back('{24, 3'b110, 1'b0, 3'd2, 1'b0, 3'b000});
        por_q.push_back('{31, 3'b110, 1'b0, 3'd2, 1'b0, 3'b000});
        por_q.push_back('{32, 3'b111, 1'b0, 3'd3, 1'b0, 3'b000});
        por_q.push_back('{33, 3'b111, 1'b1, 3'd3, 1'b0, 3'b000});
        // Edges counted from e3, the edge where RUN is left.
        soft_q.push_back('{7,  3'b110, 1'b0, 3'd4, 1'b0, 3'b000});
        soft_q.push_back('{8,  3'b100, 1'b0, 3'd5, 1'b0, 3'b000});
        soft_q.push_back('{15, 3'b100, 1'b0, 3'd5, 1'b0, 3'b000});
        soft_q.push_back('{16, 3'b110, 1'b0, 3'd2, 1'b0, 3'b000});
        soft_q.push_back('{23, 3'b110, 1'b0, 3'd2, 1'b0, 3'b000});
        soft_q.push_back('{24, 3'b111, 1'b0, 3'd3, 1'b0, 3'b000});
        soft_q.push_back('{25, 3'b111, 1'b1, 3'd3, 1'b0, 3'b000});

        e_reset_n       = 1'b0;
        soft_reboot_req = 1'b0;
        cpu_rst_rel     = 1'b1;
        #22;
        check_all_zero("reset");
        step();
        e_reset_n = 1'b1;
        run_vecs(0, 1'b0, "por");
        chk("por reboot_cnt", {24'd0, reboot_cnt}, 32'd0);

        // CPU reset follows cpu_rst_rel with one cycle of lag.
        cpu_rst_rel = 1'b0;
        #1;
        chk("cpu lag before edge", {31'd0, cpu_reset_n}, 32'd1);
        step();
        chk("cpu released->0", {31'd0, cpu_reset_n}, 32'd0);
        chk("cpu toggle s_reset_n", {31'd0, s_reset_n}, 32'd1);
        chk("cpu toggle state", {29'd0, seq_state}, 32'd3);
        cpu_rst_rel = 1'b1;
        step();
        chk("cpu back to 1", {31'd0, cpu_reset_n}, 32'd1);

        // Single soft reboot, request dropped while s_reset_n is low.
        soft_reboot_req = 1'b1;
        step();
        step();
        chk("soft e2 still RUN", {29'd0, seq_state}, 32'd3);
        chk("soft e2 s_reset_n", {31'd0, s_reset_n}, 32'd1);
        step();
        chk("soft e3 pcs", {29'd0, p_reset_n, clk_enb, s_reset_n}, 32'b110);
        chk("soft e3 cpu", {31'd0, cpu_reset_n}, 32'd0);
        chk("soft e3 state", {29'd0, seq_state}, 32'd4);
        chk("soft e3 reboot_cnt", {24'd0, reboot_cnt}, 32'd1);
        soft_reboot_req = 1'b0;
        run_vecs(1, 1'b1, "soft");
        chk("soft reboot_cnt", {24'd0, reboot_cnt}, 32'd1);

        // Held request: back-to-back reboots until the counter saturates.
        step();
        soft_reboot_req = 1'b1;
        trans = 0; run_len = 0; max_run = 0; done = 1'b0;
        for (int i = 0; i < 8000 && !done; i++) begin
            logic [2:0] prev;
            prev = seq_state;
            step();
            if (seq_state != 3'd3) begin
                if (trans > 0 && run_len > max_run) max_run = run_len;
                run_len = 0;
            end else begin
                run_len++;
            end
            if (prev == 3'd3 && seq_state == 3'd4) trans++;
            if (reboot_cnt == 8'd255) done = 1'b1;
        end
        chk("saturate reached in budget", {31'd0, done}, 32'd1);
        chk("saturate reboot count", trans, 32'd254);
        chk("back-to-back RUN length", max_run, 32'd1);
        trans_sat = trans;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] prev;
            prev = seq_state;
            step();
            if (prev == 3'd3 && seq_state == 3'd4) trans++;
        end
        chk("saturate more reboots", {31'd0, trans > trans_sat}, 32'd1);
        chk("saturate hold 255", {24'd0, reboot_cnt}, 32'd255);
        chk("saturate p_reset_n", {31'd0, p_reset_n}, 32'd1);
        soft_reboot_req = 1'b0;
        stable = 0;
        for (int i = 0; i < 200 && stable < 5; i++) begin
            step();
            stable = (seq_state == 3'd3) ? stable + 1 : 0;
        end
        chk("settle in RUN", {31'd0, stable >= 5}, 32'd1);

        // e_reset_n pulse in the middle of SOFT_CLK_OFF.
        soft_reboot_req = 1'b1;
        repeat (4) step();
        soft_reboot_req = 1'b0;
        waited = 0;
        while (seq_state != 3'd5 && waited < 50) begin
            step();
            waited++;
        end
        chk("reach SOFT_CLK_OFF", {29'd0, seq_state}, 32'd5);
        repeat (3) step();
        e_reset_n = 1'b0;
        #1;
        check_all_zero("rst mid soft_clk_off");
        step();
        e_reset_n = 1'b1;
        run_vecs(0, 1'b0, "por2");

        // e_reset_n pulse in the middle of S_WAIT.
        e_reset_n = 1'b0;
        step();
        e_reset_n = 1'b1;
        repeat (28) step();
        chk("mid S_WAIT state", {29'd0, seq_state}, 32'd2);
        chk("mid S_WAIT pcs", {29'd0, p_reset_n, clk_enb, s_reset_n}, 32'b110);
        e_reset_n = 1'b0;
        #1;
        check_all_zero("rst mid s_wait");
        step();
        e_reset_n = 1'b1;
        run_vecs(0, 1'b0, "por3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
